// File: rtl/spm_ex_arbiter.sv
// -----------------------------------------------------------------------------
// spm_ex_arbiter
//
// Round-robin arbiter and sequencer for the scratchpad external access port.
// Single-beat read/write requests from N_REQ requesters are serialised onto
// ex_in_bus one per cycle. Returned read data is routed back to the requester
// that issued the read.
//
// ex_out_bus is muxed combinationally by the read select currently driven on
// ex_in_bus. That select must therefore stay put until every in-flight read
// has returned. A read to a different bank group is held off until the read
// pipe drains. Writes never touch the read select, so they are always
// eligible.
//
// Optional feature macro: SPM_ARB_BURST_EN
//   defined   : a granted requester keeps exclusive eligibility until a beat
//               with req_last = 1 is accepted. The pointer moves only on that
//               beat.
//   undefined : req_last is ignored and every beat is arbitrated on its own.
//
// Burst lock FSM (present only with SPM_ARB_BURST_EN):
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_OPEN  | normal round-robin over all requesters
//   ST_BURST | only owner_q is eligible until its last beat is accepted
//
// Ports
//   clk         : clock, all logic rising-edge
//   rst         : asynchronous reset, active low
//   req_valid   : per-requester request valid
//   req_ready   : per-requester accept (combinational, at most one bit high)
//   req_we      : per-requester 1 = write, 0 = read
//   req_bg      : per-requester bank group, slice i = [2i+1:2i]
//   req_addr    : per-requester address slices
//   req_wdata   : per-requester write data slices
//   req_last    : per-requester last beat of a burst
//   ex_in_bus   : {write_sel, read_sel, addr, data}, registered
//   ex_wen      : qualifies write_sel this cycle
//   ex_ren      : qualifies read_sel this cycle
//   ex_out_bus  : scratchpad read data
//   rsp_valid   : one-hot read response strobe, registered
//   rsp_data    : read data, valid with rsp_valid
// -----------------------------------------------------------------------------
module spm_ex_arbiter #(
    parameter int N_REQ  = 4,
    parameter int A_W    = 8,
    parameter int D_W    = 32,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ-1:0]     req_we,
    input  logic [2*N_REQ-1:0]   req_bg,
    input  logic [A_W*N_REQ-1:0] req_addr,
    input  logic [D_W*N_REQ-1:0] req_wdata,
    input  logic [N_REQ-1:0]     req_last,
    output logic [4+A_W+D_W-1:0] ex_in_bus,
    output logic                 ex_wen,
    output logic                 ex_ren,
    input  logic [D_W-1:0]       ex_out_bus,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [D_W-1:0]       rsp_data
);

    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PIPE_D = RD_LAT + 1;

    // Round-robin pointer.
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  next_ptr;
    logic             ptr_adv;

    // Registered bus fields.
    logic [1:0]       wr_sel_q;
    logic [1:0]       rd_sel_q;
    logic [A_W-1:0]   addr_q;
    logic [D_W-1:0]   data_q;

    // Read tracking pipe: stage s holds a read issued s+1 cycles ago.
    logic [PIPE_D-1:0] pipe_vld;
    logic [ID_W-1:0]   pipe_id [PIPE_D];
    logic              rd_in_flight;

    // Arbitration.
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] lock_mask;
    logic             grant_found;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  scan_id;
    int               scan_idx;
    logic             accept;

    // Fields of the winning request.
    logic             grant_we;
    logic [1:0]       grant_bg;
    logic [A_W-1:0]   grant_addr;
    logic [D_W-1:0]   grant_wdata;

    assign rd_in_flight = |pipe_vld;

    // -------------------------------------------------------------------------
    // Burst lock
    // -------------------------------------------------------------------------
`ifdef SPM_ARB_BURST_EN
    typedef enum logic {
        ST_OPEN  = 1'b0,
        ST_BURST = 1'b1
    } burst_state_t;

    burst_state_t    state_q;
    burst_state_t    state_d;
    logic [ID_W-1:0] owner_q;
    logic [ID_W-1:0] owner_d;
    logic            grant_last;

    assign grant_last = req_last[grant_id];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_OPEN;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            ST_OPEN: begin
                // A single-beat transfer (last on first beat) never locks.
                if (accept && !grant_last) begin
                    state_d = ST_BURST;
                    owner_d = grant_id;
                end
            end
            ST_BURST: begin
                if (accept && grant_last) begin
                    state_d = ST_OPEN;
                end
            end
            default: state_d = ST_OPEN;
        endcase
    end

    always_comb begin
        lock_mask = '1;
        if (state_q == ST_BURST) begin
            lock_mask          = '0;
            lock_mask[owner_q] = 1'b1;
        end
    end

    assign ptr_adv = accept && grant_last;
`else
    logic unused_last;

    assign unused_last = ^req_last;
    assign lock_mask   = '1;
    assign ptr_adv     = accept;
`endif

    // -------------------------------------------------------------------------
    // Eligibility: a read that would change the read select while reads are
    // still returning would corrupt their data, so it waits. It blocks only
    // itself; the scan simply skips it.
    // -------------------------------------------------------------------------
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = req_valid[i] &&
                          (req_we[i] || !rd_in_flight ||
                           (req_bg[2*i +: 2] == rd_sel_q));
        end
        eligible = eligible & lock_mask;
    end

    // First eligible requester scanning upward from the pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = 0;
        scan_id     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= N_REQ) begin
                scan_idx = scan_idx - N_REQ;
            end
            scan_id = ID_W'(scan_idx);
            if (!grant_found && eligible[scan_id]) begin
                grant_found = 1'b1;
                grant_id    = scan_id;
            end
        end
    end

    assign accept = grant_found;

    // No accepts are offered while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (grant_found && rst) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign grant_we    = req_we[grant_id];
    assign grant_bg    = req_bg[2*grant_id +: 2];
    assign grant_addr  = req_addr[A_W*grant_id +: A_W];
    assign grant_wdata = req_wdata[D_W*grant_id +: D_W];

    assign next_ptr = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (ptr_adv) begin
            rr_ptr <= next_ptr;
        end
    end

    // -------------------------------------------------------------------------
    // Command issue. Unused fields hold their last value so read_sel keeps
    // steering ex_out_bus across writes and idle cycles.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_sel_q <= '0;
            rd_sel_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            ex_wen   <= 1'b0;
            ex_ren   <= 1'b0;
        end else if (accept) begin
            addr_q <= grant_addr;
            if (grant_we) begin
                wr_sel_q <= grant_bg;
                data_q   <= grant_wdata;
                ex_wen   <= 1'b1;
                ex_ren   <= 1'b0;
            end else begin
                rd_sel_q <= grant_bg;
                ex_wen   <= 1'b0;
                ex_ren   <= 1'b1;
            end
        end else begin
            ex_wen <= 1'b0;
            ex_ren <= 1'b0;
        end
    end

    assign ex_in_bus = {wr_sel_q, rd_sel_q, addr_q, data_q};

    // -------------------------------------------------------------------------
    // Read tracking. One issue per cycle bounds the outstanding reads to the
    // pipe depth, so the shift register cannot overflow.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_vld <= '0;
            for (int s = 0; s < PIPE_D; s++) begin
                pipe_id[s] <= '0;
            end
        end else begin
            pipe_vld[0] <= accept && !grant_we;
            pipe_id[0]  <= grant_id;
            for (int s = 1; s < PIPE_D; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                pipe_id[s]  <= pipe_id[s-1];
            end
        end
    end

    // The last pipe stage lines up with the read data on ex_out_bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= '0;
            if (pipe_vld[RD_LAT]) begin
                rsp_valid[pipe_id[RD_LAT]] <= 1'b1;
                rsp_data                   <= ex_out_bus;
            end
        end
    end

endmodule

// File: doc/spm_ex_arbiter.md
# spm_ex_arbiter

Round-robin arbiter and sequencer for the scratchpad's external access port. It accepts single-beat read/write requests from `N_REQ` requesters (host loader, DMA, debug), serialises them onto the scratchpad `ex_in_bus`, and routes returned read data back to the originator. It owns the read-select hazard: `ex_out_bus` is muxed combinationally by the currently driven read select, so that select must hold until every in-flight read has returned.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `A_W`, 8: scratchpad address width.
- `D_W`, 32: data width.
- `RD_LAT`, 1: cycles from a read command on `ex_in_bus` to its data on `ex_out_bus`.
- `clk`  in  1: single clock domain; all logic rising-edge.
- `rst`  in  1: asynchronous, active-low reset.
- `req_valid`  in  N_REQ: per-requester request valid.
- `req_ready`  out  N_REQ: per-requester accept; at most one bit high per cycle.
- `req_we`  in  N_REQ: 1 = write, 0 = read.
- `req_bg`  in  2*N_REQ: target bank group, slice i = `[2i+1:2i]`.
- `req_addr`  in  A_W*N_REQ: address slices.
- `req_wdata`  in  D_W*N_REQ: write data slices.
- `req_last`  in  N_REQ: last beat of a burst (used only with `SPM_ARB_BURST_EN`).
- `ex_in_bus`  out  4+A_W+D_W: `{write_sel[1:0], read_sel[1:0], addr, data}`, registered.
- `ex_wen`  out  1: qualifies `write_sel` this cycle.
- `ex_ren`  out  1: qualifies `read_sel` this cycle.
- `ex_out_bus`  in  D_W: scratchpad read data.
- `rsp_valid`  out  N_REQ: one-hot read-response strobe, registered.
- `rsp_data`  out  D_W: read data, valid with `rsp_valid`.

## Operation
- Reset values: `req_ready` = 0, `ex_in_bus` = 0, `ex_wen` = 0, `ex_ren` = 0, `rsp_valid` = 0, `rsp_data` = 0, RR pointer = 0, read pipeline empty, `rd_sel_q` = 0.
- Arbitration: each cycle, the eligible requester with `req_valid` = 1 found first scanning from the RR pointer upward (mod N_REQ) wins. `req_ready` is driven combinationally for the winner only. After an accept, the pointer becomes winner + 1 (mod N_REQ). The pointer is unchanged on cycles with no accept.
- Eligibility: a read whose `req_bg` differs from `rd_sel_q` is ineligible while any read is in flight (read-select hazard). Writes are always eligible. An ineligible request blocks only itself; the pointer moves past it to other requesters.
- Requesters hold all request fields stable while `req_valid && !req_ready`.
- Issue of an accepted write: next cycle `write_sel` = bg, `addr`, `data` = wdata, `ex_wen` = 1, `ex_ren` = 0.
- Issue of an accepted read: next cycle `read_sel` = bg, `addr`, `ex_ren` = 1, `ex_wen` = 0. `rd_sel_q` takes bg.
- Idle cycle: `ex_wen` = `ex_ren` = 0. The bus fields hold their last values, and `read_sel` always equals `rd_sel_q`.
- Read tracking: a shift register of depth `RD_LAT` + 1 holds `{valid, requester id}`. It tracks at most `RD_LAT` + 1 outstanding reads, which is the natural limit at one issue per cycle, so there is no overflow case.
- Response: when a tracked read reaches the end of the pipe, `ex_out_bus` is captured into `rsp_data` and the matching `rsp_valid` bit is set for one cycle. Responses stay in issue order.
- Asserting `rst` mid-operation drops in-flight reads immediately; no response is produced for them.

## Timing
- Accept at cycle 0 (valid && ready). Command on `ex_in_bus` in cycle 1.
- Read data on `ex_out_bus` in cycle 1 + `RD_LAT`. `rsp_valid` in cycle 2 + `RD_LAT` (cycle 3 at default).
- Throughput: one command per cycle. Back-to-back reads to the same bank group never stall. A read to a different bank group stalls until the pipe is empty.
- Simultaneous write accept and read return: both proceed. A write never changes `read_sel`.

## Configuration
- `SPM_ARB_BURST_EN` defined: once a requester is granted, it keeps exclusive eligibility until a beat with `req_last` = 1 is accepted. The pointer advances only on that last beat. Other requesters see `req_ready` = 0 during the burst. The hazard rule still applies inside a burst.
- `SPM_ARB_BURST_EN` undefined: `req_last` is ignored, and every beat is arbitrated independently.

## Test plan
- Reset: drive `rst` low mid-burst with 2 reads in flight → all outputs 0 at once, no `rsp_valid` after release, first grant goes to requester 0.
- Round-robin: requesters 0–3 hold writes (bg = i, addr = 0x10 + i, data = 0xA0 + i) → grants in order 0,1,2,3,0…, one per cycle. `ex_wen` = 1 every cycle. Bus shows matching fields one cycle after each grant.
- Read return: requester 2 reads bg1 addr 0x05 with `ex_out_bus` = 0xDEADBEEF at cycle 2 → `rsp_valid` = 4'b0100 and `rsp_data` = 0xDEADBEEF at cycle 3.
- Hazard: requester 0 reads bg0 in cycle 0, requester 1 reads bg3 in cycle 1 → requester 1 is not granted until the pipe is empty. Requester 3's write, presented in cycle 1, is granted in cycle 1.
- Burst (macro on): requester 1 issues 4 beats with `req_last` on the 4th while requester 0 is valid → 4 consecutive grants to requester 1, then requester 0. With the macro off, grants alternate 1,0,1,0.
